// File: rtl/hb_pkg.sv
// Shared constants for the heartbeat interval path: default widths, sample rate,
// refractory and asystole limits, and a constant-foldable clog2 helper.
package hb_pkg;

    localparam int HB_WIDTH          = 14;
    localparam int HB_DEPTH          = 8;
    localparam int HB_SAMPLE_RATE_HZ = 250;
    localparam int HB_MIN_RR         = 50;   // 200 ms at 250 Hz
    localparam int HB_TIMEOUT        = 750;  // 3 s at 250 Hz

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/rr_interval_buffer_if.sv
// Bus between the QRS detector / rate display side (master) and rr_interval_buffer (slave).
// rr_strobe and beat_reject are one-cycle valid pulses with no ready: consumers take them on the cycle they are high.
interface rr_interval_buffer_if
    import hb_pkg::*;
#(
    parameter int WIDTH = HB_WIDTH,
    parameter int DEPTH = HB_DEPTH
);
    localparam int LOG2D = clog2(DEPTH);

    logic             sample;
    logic             heartbeat_detect;
    logic [LOG2D-1:0] hist_addr;
    logic [WIDTH-1:0] rr_interval;
    logic             rr_strobe;
    logic [WIDTH-1:0] rr_avg;
    logic             avg_valid;
    logic [LOG2D:0]   fill_count;
    logic             beat_reject;
    logic             timeout;
    logic [WIDTH-1:0] hist_data;
    // Debug view of the internal sample counter and first-beat flag.
    logic [WIDTH-1:0] dbg_count;
    logic             dbg_first_seen;

    modport master (
        output sample, heartbeat_detect, hist_addr,
        input  rr_interval, rr_strobe, rr_avg, avg_valid, fill_count,
               beat_reject, timeout, hist_data, dbg_count, dbg_first_seen
    );

    modport slave (
        input  sample, heartbeat_detect, hist_addr,
        output rr_interval, rr_strobe, rr_avg, avg_valid, fill_count,
               beat_reject, timeout, hist_data, dbg_count, dbg_first_seen
    );

endinterface

// File: rtl/rr_hist_ram.sv
// DEPTH x WIDTH circular interval history: one write port that advances its own pointer,
// a combinational view of the slot about to be overwritten, and a registered newest-relative read.
module rr_hist_ram
    import hb_pkg::*;
#(
    parameter int WIDTH = HB_WIDTH,
    parameter int DEPTH = HB_DEPTH,
    localparam int LOG2D = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] old_data,
    input  logic [LOG2D-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2D-1:0] wptr;
    logic [LOG2D-1:0] rd_idx;

    // DEPTH is a power of two, so pointer arithmetic wraps naturally; addr 0 is the newest entry.
    assign rd_idx   = wptr - LOG2D'(1) - rd_addr;
    assign old_data = mem[wptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr    <= '0;
            rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rd_data <= mem[rd_idx];
            if (we) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + LOG2D'(1);
            end
        end
    end

endmodule

// File: rtl/rr_interval_buffer.sv
// R-R interval buffer: counts samples between accepted beats, rejects refractory beats,
// keeps a DEPTH-entry history with running sum / average, and flags asystole.
module rr_interval_buffer
    import hb_pkg::*;
#(
    parameter int WIDTH   = HB_WIDTH,
    parameter int DEPTH   = HB_DEPTH,
    parameter int MIN_RR  = HB_MIN_RR,
    parameter int TIMEOUT = HB_TIMEOUT
) (
    input logic                 clock,
    input logic                 reset,
    rr_interval_buffer_if.slave bus
);

    localparam int LOG2D = clog2(DEPTH);
    localparam int SW    = WIDTH + LOG2D;
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] MIN_RR_W  = WIDTH'(MIN_RR);
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [LOG2D:0]   FILL_MAX  = (LOG2D+1)'(DEPTH);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] e;
    logic             first_seen;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    sum_nxt;
    logic [LOG2D:0]   fill_count;
    logic             full;
    logic             accept;
    logic             reject;
    logic [WIDTH-1:0] old_data;
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] rr_interval_q;
    logic             rr_strobe_q;
    logic             beat_reject_q;
    logic             timeout_q;

    // e folds in a same-cycle sample and saturates, so it is also the counter's next value.
    always_comb begin
        e = count;
        if (bus.sample && (count != CNT_MAX)) e = count + WIDTH'(1);
        full    = (fill_count == FILL_MAX);
        accept  = bus.heartbeat_detect && first_seen && (e >= MIN_RR_W);
        reject  = bus.heartbeat_detect && first_seen && (e <  MIN_RR_W);
        sum_nxt = sum + SW'(e) - (full ? SW'(old_data) : SW'(0));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count         <= '0;
            first_seen    <= 1'b0;
            sum           <= '0;
            fill_count    <= '0;
            rr_interval_q <= '0;
            rr_strobe_q   <= 1'b0;
            beat_reject_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            rr_strobe_q   <= 1'b0;
            beat_reject_q <= 1'b0;
            if (bus.heartbeat_detect && !first_seen) begin
                first_seen <= 1'b1;
                count      <= '0;
                timeout_q  <= 1'b0;
            end else if (accept) begin
                count         <= '0;
                timeout_q     <= 1'b0;
                rr_interval_q <= e;
                rr_strobe_q   <= 1'b1;
                sum           <= sum_nxt;
                if (!full) fill_count <= fill_count + (LOG2D+1)'(1);
            end else begin
                count <= e;
                if (reject) beat_reject_q <= 1'b1;
                // Asystole only makes sense once a reference beat exists.
                if (first_seen && (e >= TIMEOUT_W)) timeout_q <= 1'b1;
            end
        end
    end

    rr_hist_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_hist (
        .clock    (clock),
        .reset    (reset),
        .we       (accept),
        .wdata    (e),
        .old_data (old_data),
        .rd_addr  (bus.hist_addr),
        .rd_data  (hist_q)
    );

    assign bus.rr_interval    = rr_interval_q;
    assign bus.rr_strobe      = rr_strobe_q;
    assign bus.rr_avg         = sum[SW-1:LOG2D];
    assign bus.avg_valid      = full;
    assign bus.fill_count     = fill_count;
    assign bus.beat_reject    = beat_reject_q;
    assign bus.timeout        = timeout_q;
    assign bus.hist_data      = hist_q;
    assign bus.dbg_count      = count;
    assign bus.dbg_first_seen = first_seen;

endmodule

// File: tb/tb_rr_interval_buffer.sv
// Directed bench for rr_interval_buffer: a default-width instance and a WIDTH=10 instance
// for timeout and counter saturation.
module tb_rr_interval_buffer;
    import hb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    rr_interval_buffer_if #(.WIDTH(14), .DEPTH(8)) bus ();
    rr_interval_buffer_if #(.WIDTH(10), .DEPTH(8)) bus10 ();

    rr_interval_buffer #(.WIDTH(14), .DEPTH(8), .MIN_RR(50), .TIMEOUT(750)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    rr_interval_buffer #(.WIDTH(10), .DEPTH(8), .MIN_RR(50), .TIMEOUT(750)) u_dut10 (
        .clock (clock),
        .reset (reset),
        .bus   (bus10)
    );

    // ---------------- clock/reset and driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sample = 1'b0;   bus.heartbeat_detect = 1'b0;   bus.hist_addr = '0;
        bus10.sample = 1'b0; bus10.heartbeat_detect = 1'b0; bus10.hist_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic samples(input bit use10, input int n);
        for (int i = 0; i < n; i++) begin
            if (use10) bus10.sample = 1'b1; else bus.sample = 1'b1;
            tick();
        end
        bus.sample = 1'b0;
        bus10.sample = 1'b0;
    endtask

    task automatic detect(input bit use10, input bit with_sample);
        if (use10) begin
            bus10.heartbeat_detect = 1'b1; bus10.sample = with_sample;
        end else begin
            bus.heartbeat_detect = 1'b1;   bus.sample = with_sample;
        end
        tick();
        bus.heartbeat_detect = 1'b0;   bus.sample = 1'b0;
        bus10.heartbeat_detect = 1'b0; bus10.sample = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.rr_interval !== 14'd0) $display("FAIL reset_rr_interval: got %0d want 0", bus.rr_interval); else n_pass++;
        n_checks++; if (bus.rr_strobe !== 1'b0) $display("FAIL reset_rr_strobe: got %0b want 0", bus.rr_strobe); else n_pass++;
        n_checks++; if (bus.rr_avg !== 14'd0) $display("FAIL reset_rr_avg: got %0d want 0", bus.rr_avg); else n_pass++;
        n_checks++; if (bus.avg_valid !== 1'b0) $display("FAIL reset_avg_valid: got %0b want 0", bus.avg_valid); else n_pass++;
        n_checks++; if (bus.fill_count !== 4'd0) $display("FAIL reset_fill_count: got %0d want 0", bus.fill_count); else n_pass++;
        n_checks++; if (bus.beat_reject !== 1'b0) $display("FAIL reset_beat_reject: got %0b want 0", bus.beat_reject); else n_pass++;
        n_checks++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %0b want 0", bus.timeout); else n_pass++;
        n_checks++; if (bus.hist_data !== 14'd0) $display("FAIL reset_hist_data: got %0d want 0", bus.hist_data); else n_pass++;
        n_checks++; if (bus10.timeout !== 1'b0) $display("FAIL reset_timeout10: got %0b want 0", bus10.timeout); else n_pass++;
    endtask

    task automatic test_regular();
        do_reset();
        detect(0, 0);
        n_checks++; if (bus.rr_strobe !== 1'b0) $display("FAIL regular_first_no_strobe: got %0b want 0", bus.rr_strobe); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            samples(0, 200);
            detect(0, 0);
            n_checks++; if (bus.rr_strobe !== 1'b1) $display("FAIL regular_strobe beat %0d: got %0b want 1", k, bus.rr_strobe); else n_pass++;
            n_checks++; if (bus.rr_interval !== 14'd200) $display("FAIL regular_interval beat %0d: got %0d want 200", k, bus.rr_interval); else n_pass++;
            n_checks++; if (bus.fill_count !== 4'(k)) $display("FAIL regular_fill beat %0d: got %0d want %0d", k, bus.fill_count, k); else n_pass++;
            n_checks++; if (bus.avg_valid !== (k == 8)) $display("FAIL regular_avg_valid beat %0d: got %0b want %0b", k, bus.avg_valid, (k == 8)); else n_pass++;
            n_checks++; if (bus.rr_avg !== 14'((200 * k) / 8)) $display("FAIL regular_avg beat %0d: got %0d want %0d", k, bus.rr_avg, (200 * k) / 8); else n_pass++;
        end
        tick();
        n_checks++; if (bus.rr_strobe !== 1'b0) $display("FAIL regular_strobe_drops: got %0b want 0", bus.rr_strobe); else n_pass++;
        for (int a = 0; a < 8; a++) begin
            bus.hist_addr = 3'(a);
            tick();
            n_checks++; if (bus.hist_data !== 14'd200) $display("FAIL regular_hist addr %0d: got %0d want 200", a, bus.hist_data); else n_pass++;
        end
        bus.hist_addr = '0;
    endtask

    task automatic test_sliding();
        do_reset();
        detect(0, 0);
        for (int k = 0; k < 8; k++) begin
            samples(0, 200);
            detect(0, 0);
        end
        n_checks++; if (bus.rr_avg !== 14'd200) $display("FAIL sliding_avg_before: got %0d want 200", bus.rr_avg); else n_pass++;
        samples(0, 400);
        detect(0, 0);
        n_checks++; if (bus.rr_interval !== 14'd400) $display("FAIL sliding_interval: got %0d want 400", bus.rr_interval); else n_pass++;
        n_checks++; if (bus.rr_avg !== 14'd225) $display("FAIL sliding_avg_after: got %0d want 225", bus.rr_avg); else n_pass++;
        n_checks++; if (bus.fill_count !== 4'd8) $display("FAIL sliding_fill: got %0d want 8", bus.fill_count); else n_pass++;
        bus.hist_addr = 3'd0; tick();
        n_checks++; if (bus.hist_data !== 14'd400) $display("FAIL sliding_hist0: got %0d want 400", bus.hist_data); else n_pass++;
        bus.hist_addr = 3'd1; tick();
        n_checks++; if (bus.hist_data !== 14'd200) $display("FAIL sliding_hist1: got %0d want 200", bus.hist_data); else n_pass++;
        bus.hist_addr = 3'd7; tick();
        n_checks++; if (bus.hist_data !== 14'd200) $display("FAIL sliding_hist7: got %0d want 200", bus.hist_data); else n_pass++;
        bus.hist_addr = '0;
    endtask

    task automatic test_refractory();
        do_reset();
        detect(0, 0);
        samples(0, 30);
        detect(0, 0);
        n_checks++; if (bus.beat_reject !== 1'b1) $display("FAIL refractory_reject: got %0b want 1", bus.beat_reject); else n_pass++;
        n_checks++; if (bus.rr_strobe !== 1'b0) $display("FAIL refractory_no_strobe: got %0b want 0", bus.rr_strobe); else n_pass++;
        n_checks++; if (bus.fill_count !== 4'd0) $display("FAIL refractory_fill: got %0d want 0", bus.fill_count); else n_pass++;
        tick();
        n_checks++; if (bus.beat_reject !== 1'b0) $display("FAIL refractory_reject_pulse: got %0b want 0", bus.beat_reject); else n_pass++;
        samples(0, 220);
        detect(0, 0);
        n_checks++; if (bus.rr_strobe !== 1'b1) $display("FAIL refractory_accept_strobe: got %0b want 1", bus.rr_strobe); else n_pass++;
        n_checks++; if (bus.rr_interval !== 14'd250) $display("FAIL refractory_interval: got %0d want 250", bus.rr_interval); else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        detect(0, 0);
        samples(0, 99);
        n_checks++; if (bus.dbg_count !== 14'd99) $display("FAIL same_cycle_count_before: got %0d want 99", bus.dbg_count); else n_pass++;
        detect(0, 1);
        n_checks++; if (bus.rr_interval !== 14'd100) $display("FAIL same_cycle_interval: got %0d want 100", bus.rr_interval); else n_pass++;
        n_checks++; if (bus.dbg_count !== 14'd0) $display("FAIL same_cycle_count_after: got %0d want 0", bus.dbg_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        detect(0, 0);
        samples(0, 100);
        bus.heartbeat_detect = 1'b1;
        tick();
        n_checks++; if (bus.rr_strobe !== 1'b1) $display("FAIL b2b_first_strobe: got %0b want 1", bus.rr_strobe); else n_pass++;
        n_checks++; if (bus.rr_interval !== 14'd100) $display("FAIL b2b_first_interval: got %0d want 100", bus.rr_interval); else n_pass++;
        tick();
        bus.heartbeat_detect = 1'b0;
        n_checks++; if (bus.beat_reject !== 1'b1) $display("FAIL b2b_second_reject: got %0b want 1", bus.beat_reject); else n_pass++;
        n_checks++; if (bus.rr_strobe !== 1'b0) $display("FAIL b2b_second_no_strobe: got %0b want 0", bus.rr_strobe); else n_pass++;
        n_checks++; if (bus.fill_count !== 4'd1) $display("FAIL b2b_fill: got %0d want 1", bus.fill_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        detect(0, 0);
        for (int k = 0; k < 3; k++) begin
            samples(0, 120);
            detect(0, 0);
        end
        n_checks++; if (bus.fill_count !== 4'd3) $display("FAIL reset_mid_fill_before: got %0d want 3", bus.fill_count); else n_pass++;
        n_checks++; if (bus.rr_avg !== 14'd45) $display("FAIL reset_mid_avg_before: got %0d want 45", bus.rr_avg); else n_pass++;
        reset = 1'b0; bus.heartbeat_detect = 1'b1; bus.sample = 1'b1;
        tick();
        reset = 1'b1; bus.heartbeat_detect = 1'b0; bus.sample = 1'b0;
        n_checks++; if (bus.fill_count !== 4'd0) $display("FAIL reset_mid_fill: got %0d want 0", bus.fill_count); else n_pass++;
        n_checks++; if (bus.rr_interval !== 14'd0) $display("FAIL reset_mid_interval: got %0d want 0", bus.rr_interval); else n_pass++;
        n_checks++; if (bus.rr_avg !== 14'd0) $display("FAIL reset_mid_avg: got %0d want 0", bus.rr_avg); else n_pass++;
        n_checks++; if (bus.dbg_count !== 14'd0) $display("FAIL reset_mid_count: got %0d want 0", bus.dbg_count); else n_pass++;
        n_checks++; if (bus.dbg_first_seen !== 1'b0) $display("FAIL reset_mid_first_seen: got %0b want 0", bus.dbg_first_seen); else n_pass++;
        tick();
        n_checks++; if (bus.hist_data !== 14'd0) $display("FAIL reset_mid_hist: got %0d want 0", bus.hist_data); else n_pass++;
        detect(0, 0);
        n_checks++; if (bus.rr_strobe !== 1'b0) $display("FAIL reset_mid_first_no_strobe: got %0b want 0", bus.rr_strobe); else n_pass++;
        samples(0, 60);
        detect(0, 0);
        n_checks++; if (bus.rr_strobe !== 1'b1) $display("FAIL reset_mid_next_strobe: got %0b want 1", bus.rr_strobe); else n_pass++;
        n_checks++; if (bus.rr_interval !== 14'd60) $display("FAIL reset_mid_next_interval: got %0d want 60", bus.rr_interval); else n_pass++;
        n_checks++; if (bus.fill_count !== 4'd1) $display("FAIL reset_mid_next_fill: got %0d want 1", bus.fill_count); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        samples(1, 800);
        n_checks++; if (bus10.timeout !== 1'b0) $display("FAIL timeout_before_first: got %0b want 0", bus10.timeout); else n_pass++;
        detect(1, 0);
        n_checks++; if (bus10.dbg_count !== 10'd0) $display("FAIL timeout_first_count: got %0d want 0", bus10.dbg_count); else n_pass++;
        samples(1, 749);
        n_checks++; if (bus10.timeout !== 1'b0) $display("FAIL timeout_at_749: got %0b want 0", bus10.timeout); else n_pass++;
        samples(1, 1);
        n_checks++; if (bus10.timeout !== 1'b1) $display("FAIL timeout_at_750: got %0b want 1", bus10.timeout); else n_pass++;
        samples(1, 50);
        n_checks++; if (bus10.timeout !== 1'b1) $display("FAIL timeout_hold_800: got %0b want 1", bus10.timeout); else n_pass++;
        samples(1, 300);
        n_checks++; if (bus10.dbg_count !== 10'd1023) $display("FAIL timeout_saturate: got %0d want 1023", bus10.dbg_count); else n_pass++;
        detect(1, 1);
        n_checks++; if (bus10.rr_interval !== 10'd1023) $display("FAIL timeout_interval: got %0d want 1023", bus10.rr_interval); else n_pass++;
        n_checks++; if (bus10.rr_strobe !== 1'b1) $display("FAIL timeout_strobe: got %0b want 1", bus10.rr_strobe); else n_pass++;
        n_checks++; if (bus10.timeout !== 1'b0) $display("FAIL timeout_cleared: got %0b want 0", bus10.timeout); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_regular();
        test_sliding();
        test_refractory();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_interval_buffer.md
Name: rr_interval_buffer

Overview:
Parametrised successor to the single-interval heartbeat buffer. Counts ADC sample strobes between accepted heartbeat detections and records each R-R interval (in samples) in a DEPTH-entry circular history. Maintains a running sum and a sliding-window average, and rejects beats inside a refractory window. Flags asystole when no beat arrives within TIMEOUT samples. Sits between the QRS detector and the heart-rate / display logic.

Parameters:
WIDTH, 14, bit width of sample counter and interval values
DEPTH, 8, history entries; power of two, 2..64; LOG2D = log2(DEPTH)
MIN_RR, 50, refractory limit in samples (200 ms at 250 Hz); beats with interval < MIN_RR are rejected
TIMEOUT, 750, samples without an accepted beat before timeout asserts (3 s at 250 Hz); must be < 2^WIDTH-1

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
sample  in  1  one-cycle strobe per ADC sample
heartbeat_detect  in  1  one-cycle strobe from QRS detector
rr_interval  out  WIDTH  most recent accepted interval, in samples
rr_strobe  out  1  one-cycle pulse when rr_interval and history are updated
rr_avg  out  WIDTH  sum of history >> LOG2D
avg_valid  out  1  high once DEPTH intervals are stored
fill_count  out  LOG2D+1  number of valid history entries, 0..DEPTH
beat_reject  out  1  one-cycle pulse when a detection is rejected
timeout  out  1  level; no accepted beat for >= TIMEOUT samples
hist_addr  in  LOG2D  history read index; 0 = newest, DEPTH-1 = oldest
hist_data  out  WIDTH  registered history read; 1-cycle latency from hist_addr

Behaviour:
- Reset (reset=0 at a clock edge): count, all history entries, sum, fill_count, rr_interval, rr_avg, hist_data = 0. rr_strobe, beat_reject, avg_valid, timeout = 0. The first_seen flag is cleared. Reset overrides any same-cycle sample or detection.
- Counter: increments on sample and saturates at 2^WIDTH-1 (no wrap).
- Effective interval for a detection cycle: e = count + sample (a same-cycle sample is included). Width is WIDTH; saturate at the max value.
- Detection with first_seen=0: set first_seen, count <= 0, clear timeout. No push, no rr_strobe, no reject.
- Detection with first_seen=1 and e < MIN_RR: beat_reject=1 next cycle. Count continues (count <= e). History, sum and timeout are unchanged.
- Detection with first_seen=1 and e >= MIN_RR (accept):
  - Write e at the write pointer and advance the pointer modulo DEPTH.
  - sum <= sum + e - (overwritten entry if fill_count==DEPTH, else 0).
  - fill_count increments, saturating at DEPTH.
  - rr_interval <= e, rr_strobe=1 next cycle, count <= 0, timeout <= 0.
- Latency: registered outputs (rr_interval, rr_strobe, fill_count, sum) change on the edge after the detection cycle. rr_avg is combinational from the sum register, so it is coherent with rr_strobe.
- sum width: WIDTH+LOG2D; it never overflows.
- avg_valid = (fill_count==DEPTH). Before that, rr_avg still reports sum>>LOG2D and consumers must ignore it.
- timeout: set on the edge where the counter reaches TIMEOUT (only when first_seen=1). It holds until the next accepted beat or reset; a rejected beat does not clear it.
- History read: hist_data <= entry[(wptr-1-hist_addr) mod DEPTH], updated every cycle. Entries not yet written read 0.
- Back-to-back detections on consecutive cycles are each evaluated independently. The second one sees e = 0 or 1, which is below MIN_RR, so it is rejected.

Decomposition:
- Shared package: hb_pkg, holding default WIDTH, sample rate, MIN_RR and TIMEOUT constants and a clog2 function.
- Sub-module: rr_hist_ram, a DEPTH x WIDTH circular store with one write port and a registered read port, plus its pointer. The top level keeps the counter, accept/reject logic, sum and flags.

Test Plan:
- Reset mid-stream: drive reset=0 for 1 cycle after 3 accepted beats -> all outputs 0, fill_count=0. The next detection only sets first_seen (no strobe).
- Regular rhythm: detections every 200 samples for 9 beats -> 8 strobes, rr_interval=200 each, avg_valid rises on the 8th strobe, rr_avg=200, hist_data=200 for every addr.
- Refractory: detections at sample 0, 30, 250 -> pulse at 30 gives beat_reject=1 and no strobe. The beat at 250 gives rr_interval=250.
- Same-cycle sample+detect: count=99 with sample=1 and detect=1 -> rr_interval=100, count=0 next cycle.
- Sliding window: 8 intervals of 200, then one of 400 -> sum 1600->1800, rr_avg=225, hist_data(addr 0)=400, (addr 7)=200.
- Timeout/saturation (use WIDTH=10): 800 samples without a beat -> timeout=1 from sample 750. Count saturates at 1023. The next beat gives rr_interval=1023 and clears timeout.
